// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter: picks one of N_REQ requesters and presents it as an index plus valid.
// Each grant lasts at most GRANT_CYCLES clocks before rotating to the next active requester.
module rr_index_arbiter #(
    parameter int IDX_W        = 3,
    parameter int GRANT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(1<<IDX_W)-1:0] req,
    input  logic                  release_req,
    output logic [IDX_W-1:0]      idx,
    output logic                  valid,
    output logic [7:0]            cnt
);

    localparam int                N_REQ    = 1 << IDX_W;
    localparam logic              ST_IDLE  = 1'b0;
    localparam logic              ST_GRANT = 1'b1;
    localparam logic [7:0]        CNT_LOAD = 8'(GRANT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    logic             state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic [7:0]       cnt_r, cnt_s;
    logic             end_s;

    // First requester found searching upward from p, wrapping modulo N_REQ.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                     input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] win;
        win = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = p + IDX_W'(i);
            if (r[cand]) begin
                win = cand;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Next-state and grant selection.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        end_s   = (cnt_r == 8'd0) | release_req | ~req[idx_r];
        case (state_r)
            ST_IDLE: begin
                if (req != '0) begin
                    state_s = ST_GRANT;
                    idx_s   = pick_winner(req, ptr_r);
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (end_s) begin
                    // Search starts just past the current holder so it is found last.
                    ptr_s = idx_r + IDX_ONE;
                    if (req != '0) begin
                        idx_s = pick_winner(req, idx_r + IDX_ONE);
                        cnt_s = CNT_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = 8'd0;
                    end
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            ptr_r   <= '0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
        end
    end

    assign idx   = idx_r;
    assign valid = state_r;
    assign cnt   = cnt_r;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter: directed scenarios with fixed expectations plus
// randomized traffic compared against a queue-free arithmetic reference model.
module tb_rr_index_arbiter;

    localparam int GC = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       release_req;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] cnt;

    int n_checks;
    int n_errors;

    // Reference model state.
    int m_valid;
    int m_idx;
    int m_cnt;
    int m_ptr;

    rr_index_arbiter #(.IDX_W(3), .GRANT_CYCLES(GC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .release_req (release_req),
        .idx         (idx),
        .valid       (valid),
        .cnt         (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_winner(input logic [7:0] r, input int p);
        for (int off = 0; off < 8; off++) begin
            if (r[(p + off) % 8]) return (p + off) % 8;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    // Apply one posedge to the model using the inputs currently driven.
    task automatic model_edge();
        bit done;
        if (m_valid == 0) begin
            if (req != 8'd0) begin
                m_idx   = ref_winner(req, m_ptr);
                m_cnt   = GC - 1;
                m_valid = 1;
            end
        end else begin
            done = (m_cnt == 0) || (release_req == 1'b1) || (req[m_idx] == 1'b0);
            if (done) begin
                m_ptr = (m_idx + 1) % 8;
                if (req != 8'd0) begin
                    m_idx = ref_winner(req, m_ptr);
                    m_cnt = GC - 1;
                end else begin
                    m_valid = 0;
                    m_cnt   = 0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".valid"}, int'(valid), m_valid);
        check({tag, ".idx"},   int'(idx),   m_idx);
        if (m_valid != 0) check({tag, ".cnt"}, int'(cnt), m_cnt);
    endtask

    // Assert reset between edges; optionally check that outputs clear before any edge.
    task automatic apply_reset(input bit chk);
        rst = 1'b0;
        #2;
        if (chk) begin
            check("rst.valid", int'(valid), 0);
            check("rst.idx",   int'(idx),   0);
            check("rst.cnt",   int'(cnt),   0);
        end
        req         = 8'd0;
        release_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        req         = 8'd0;
        release_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Idle latency: nothing before the request is sampled.
        for (int k = 0; k < 3; k++) step("idle");
        req = 8'h01;
        check("lat.pre", int'(valid), 0);
        step("lat");
        check("lat.valid", int'(valid), 1);
        check("lat.idx", int'(idx), 0);

        // Sole requester: idx 5 continuously, cnt 3,2,1,0,3...
        apply_reset(1'b0);
        req = 8'h20;
        for (int k = 0; k < 12; k++) begin
            step("sole");
            check("sole.idx", int'(idx), 5);
            check("sole.cnt", int'(cnt), 3 - (k % 4));
        end

        // Mid-grant reset clears immediately.
        apply_reset(1'b1);

        // Two requesters 0 and 7 alternate in blocks of four, wrapping 7 -> 0.
        req = 8'h81;
        for (int k = 0; k < 16; k++) begin
            step("two");
            check("two.valid", int'(valid), 1);
            check("two.idx", int'(idx), ((k / 4) % 2 == 0) ? 0 : 7);
        end

        // Early release on the second grant cycle of idx 1.
        apply_reset(1'b0);
        req = 8'h06;
        step("rel1");
        check("rel.first", int'(idx), 1);
        step("rel2");
        check("rel.second_cnt", int'(cnt), 2);
        release_req = 1'b1;
        step("rel3");
        release_req = 1'b0;
        check("rel.idx", int'(idx), 2);
        check("rel.cnt", int'(cnt), 3);

        // Requester drops mid-grant, then a new one arrives.
        apply_reset(1'b0);
        req = 8'h08;
        step("drop1");
        step("drop2");
        req = 8'h00;
        step("drop3");
        check("drop.valid", int'(valid), 0);
        check("drop.idx", int'(idx), 3);
        release_req = 1'b1;
        step("drop_rel_idle");
        release_req = 1'b0;
        req = 8'h10;
        step("drop4");
        check("drop.new_idx", int'(idx), 4);
        check("drop.new_valid", int'(valid), 1);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 3))
                0: req = 8'd0;
                1: req = 8'(1 << $urandom_range(0, 7));
                2: req = 8'($urandom) & 8'($urandom);
                default: req = req;
            endcase
            release_req = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) begin
                apply_reset(1'b1);
            end else begin
                step("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
